// File: rtl/flit_pkg.sv
// flit_pkg: shared flit geometry, FSM states and chunk helper for the NoC flit compressor/decompressor.
package flit_pkg;
  localparam int FLIT_WIDTH = 128;
  localparam int CHUNK_SIZE = 8;
  localparam int CHUNKS = FLIT_WIDTH / CHUNK_SIZE;
  localparam int EN_BITS = 3;
  localparam int BE_PAIR = EN_BITS + CHUNK_SIZE;
  localparam int BODY_FLITS = 4;
  localparam int META_START = 75;
  localparam int META_W = BODY_FLITS * BE_PAIR;
  localparam int CNT_W = $clog2(BODY_FLITS);
  localparam logic [EN_BITS-1:0] EN_RAW = '0;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT_HEAD, EMIT_BODY} state_t;
  function automatic logic [CHUNK_SIZE-1:0] chunk(input logic [FLIT_WIDTH-1:0] f, input int i);
    return f[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE];
  endfunction
endpackage

// File: rtl/be_pair_gen.sv
// be_pair_gen: combinational base/encoding pair for one flit (min-relative delta, raw when range needs 8 bits).
module be_pair_gen
  import flit_pkg::*;
(
  input  logic [FLIT_WIDTH-1:0] flit,
  output logic [EN_BITS-1:0]    en_bits,
  output logic [CHUNK_SIZE-1:0] base,
  output logic [CHUNK_SIZE-1:0] mn,
  output logic                  raw
);
  logic [CHUNK_SIZE-1:0] mx, rng;
  logic [EN_BITS-1:0] w;
  always_comb begin
    mn = '1;
    mx = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      mn = chunk(flit, i) < mn ? chunk(flit, i) : mn;
      mx = chunk(flit, i) > mx ? chunk(flit, i) : mx;
    end
    rng = mx - mn;
    w = EN_BITS'(1);
    for (int k = 1; k < CHUNK_SIZE - 1; k++) w = rng[k] ? EN_BITS'(k + 1) : w;
    raw = rng[CHUNK_SIZE-1];
    en_bits = raw ? EN_RAW : w;
    base = raw ? '0 : -mn;
  end
endmodule

// File: rtl/flit_compressor.sv
// flit_compressor: buffers one head+body packet, delta-encodes the bodies and emits head (with pair metadata) then bodies.
module flit_compressor
  import flit_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_head,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_head,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  proto_err
);
  state_t state, state_nx;
  logic [CNT_W-1:0] bcnt, ocnt;
  logic [FLIT_WIDTH-1:0] head_buf, head_out, enc;
  logic [BODY_FLITS-1:0][FLIT_WIDTH-1:0] body_buf;
  logic [BODY_FLITS-1:0][BE_PAIR-1:0] meta;
  logic [EN_BITS-1:0] en_bits;
  logic [CHUNK_SIZE-1:0] base, mn;
  logic raw, acc, bad, last_body;

  be_pair_gen u_pair (.flit(data_in), .en_bits(en_bits), .base(base), .mn(mn), .raw(raw));

  // Bodies are stored already encoded so emission is a plain buffer read.
  for (genvar i = 0; i < CHUNKS; i++) begin : g_enc
    assign enc[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] = raw ? chunk(data_in, i) : chunk(data_in, i) - mn;
  end

  assign in_ready = rst_n_in && (state == IDLE || state == COLLECT);
  assign acc = in_valid && in_ready;
  assign bad = acc && (in_is_head == (state == COLLECT));
  assign last_body = bcnt == CNT_W'(BODY_FLITS - 1);
  assign out_valid = state == EMIT_HEAD || state == EMIT_BODY;
  assign out_is_head = state == EMIT_HEAD;
  assign data_out = state == EMIT_HEAD ? head_out : state == EMIT_BODY ? body_buf[ocnt] : '0;

  always_comb begin
    head_out = head_buf;
    for (int i = 0; i < BODY_FLITS; i++) head_out[META_START-i*BE_PAIR -: BE_PAIR] = meta[i];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = acc && in_is_head ? COLLECT : IDLE;
      COLLECT:   state_nx = acc && !in_is_head && last_body ? EMIT_HEAD : COLLECT;
      EMIT_HEAD: state_nx = out_ready ? EMIT_BODY : EMIT_HEAD;
      EMIT_BODY: state_nx = out_ready && ocnt == CNT_W'(BODY_FLITS - 1) ? IDLE : EMIT_BODY;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      bcnt <= '0;
      ocnt <= '0;
      head_buf <= '0;
      body_buf <= '0;
      meta <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      proto_err <= bad;
      if (acc && in_is_head) begin
        head_buf <= data_in;
        bcnt <= '0;
      end
      if (acc && !in_is_head && state == COLLECT) begin
        body_buf[bcnt] <= enc;
        meta[bcnt] <= {en_bits, base};
        bcnt <= bcnt + 1'b1;
      end
      if (out_valid && out_ready) ocnt <= state == EMIT_HEAD ? '0 : ocnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_flit_compressor.sv
// tb_flit_compressor: directed packets checked every output cycle against a queue-based compression model plus loopback decode.
module tb_flit_compressor;
  import flit_pkg::*;
  typedef logic [127:0] flit_t;

  logic clk_in = 0, rst_n_in = 0, in_valid = 0, in_is_head = 0, out_ready = 1;
  flit_t data_in = '0;
  logic in_ready, out_valid, out_is_head, proto_err;
  flit_t data_out;

  int tests = 0, fails = 0;
  int out_cnt = 0, perr_cnt = 0;
  flit_t exp_q[$], orig_q[$];
  logic exp_head_q[$];
  logic [10:0] mt[4];
  int bi = 0;
  logic stall = 0, ph = 0;
  flit_t pd = '0;

  always #5 clk_in = ~clk_in;

  flit_compressor dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_head(in_is_head), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_head(out_is_head), .data_out(data_out), .proto_err(proto_err)
  );

  task automatic check(input string name, input flit_t act, input flit_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [10:0] model_pair(input flit_t f, output flit_t enc);
    int mn, mx, w, c;
    mn = 255;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      c = int'(f[127-8*i -: 8]);
      if (c < mn) mn = c;
      if (c > mx) mx = c;
    end
    w = (mx == mn) ? 1 : $clog2(mx - mn + 1);
    enc = f;
    if (w > 7) return 11'h000;
    for (int i = 0; i < 16; i++) enc[127-8*i -: 8] = 8'(int'(f[127-8*i -: 8]) - mn);
    return {3'(w), 8'((256 - mn) % 256)};
  endfunction

  task automatic expect_packet(input flit_t h, input flit_t b0, input flit_t b1, input flit_t b2, input flit_t b3);
    flit_t b[4] = '{b0, b1, b2, b3};
    flit_t e[4];
    logic [43:0] m;
    for (int k = 0; k < 4; k++) m[43-11*k -: 11] = model_pair(b[k], e[k]);
    h[75:32] = m;
    exp_q.push_back(h);
    exp_head_q.push_back(1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(e[k]);
      exp_head_q.push_back(1'b0);
      orig_q.push_back(b[k]);
    end
  endtask

  task automatic send(input logic hd, input flit_t d);
    bit ok = 0;
    in_valid = 1;
    in_is_head = hd;
    data_in = d;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk_in);
      ok = in_ready;
    end
    @(posedge clk_in);
    #1;
    in_valid = 0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready never rose for flit %h", d);
    end
  endtask

  task automatic send_pkt(input flit_t h, input flit_t b0, input flit_t b1, input flit_t b2, input flit_t b3);
    send(1, h);
    send(0, b0);
    send(0, b1);
    send(0, b2);
    send(0, b3);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && (exp_q.size() != 0 || out_valid); n++) @(posedge clk_in);
    #1;
    check("drain_queue_empty", flit_t'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, flit_t'(in_ready), 0);
    check({tag, "_out_valid"}, flit_t'(out_valid), 0);
    check({tag, "_out_is_head"}, flit_t'(out_is_head), 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_proto_err"}, flit_t'(proto_err), 0);
  endtask

  always @(negedge clk_in) begin
    flit_t e, o, dec;
    logic eh;
    if (proto_err) perr_cnt++;
    if (stall) begin
      check("hold_valid", flit_t'(out_valid), 1);
      check("hold_data", data_out, pd);
      check("hold_is_head", flit_t'(out_is_head), flit_t'(ph));
    end
    if (out_valid) check("in_ready_low_while_emitting", flit_t'(in_ready), 0);
    stall = out_valid && !out_ready;
    pd = data_out;
    ph = out_is_head;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_flit: got %h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        eh = exp_head_q.pop_front();
        check("out_data", data_out, e);
        check("out_is_head", flit_t'(out_is_head), flit_t'(eh));
        if (eh) begin
          for (int k = 0; k < 4; k++) mt[k] = data_out[75-11*k -: 11];
          bi = 0;
        end else if (bi < 4 && orig_q.size() != 0) begin
          o = orig_q.pop_front();
          for (int c = 0; c < 16; c++)
            dec[127-8*c -: 8] = mt[bi][10:8] != 0 ? data_out[127-8*c -: 8] - mt[bi][7:0] : data_out[127-8*c -: 8];
          check("loopback_decode", dec, o);
          bi++;
        end
      end
    end
  end

  localparam flit_t UNI  = {16{8'h10}};
  localparam flit_t RAMP = 128'h000102030405060708090A0B0C0D0E0F;
  localparam flit_t MIX  = {8{16'h00FF}};
  localparam flit_t HI   = 128'h808182838485868788898A8B8C8D8E8F;
  localparam flit_t DOWN = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam flit_t R127 = 128'h0000000000000000000000000000007F;
  localparam flit_t R128 = 128'h00000000000000000000000000000080;
  localparam flit_t MID  = 128'h404142434445464748494A4B4C4D4E4F;

  initial begin
    flit_t tmp;
    int c0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_n_in = 1;
    @(posedge clk_in);
    #1;
    check("pin_pair_uniform", flit_t'(model_pair(UNI, tmp)), 11'h1F0);
    check("pin_enc_uniform", tmp, 0);
    check("pin_pair_ramp", flit_t'(model_pair(RAMP, tmp)), 11'h400);
    check("pin_enc_ramp", tmp, RAMP);
    check("pin_pair_mixed", flit_t'(model_pair(MIX, tmp)), 11'h000);
    check("pin_pair_hi", flit_t'(model_pair(HI, tmp)), 11'h480);
    check("pin_enc_hi", tmp, RAMP);
    check("pin_pair_down", flit_t'(model_pair(DOWN, tmp)), 11'h410);
    check("pin_pair_r127", flit_t'(model_pair(R127, tmp)), 11'h700);
    check("pin_pair_r128", flit_t'(model_pair(R128, tmp)), 11'h000);

    expect_packet(128'h0123456789ABCDEFFEDCBA9876543210, UNI, RAMP, MIX, HI);
    send_pkt(128'h0123456789ABCDEFFEDCBA9876543210, UNI, RAMP, MIX, HI);
    wait_drain();

    out_ready = 0;
    expect_packet(128'hDEADBEEFCAFEF00D5555AAAA3333CCCC, DOWN, R127, R128, MID);
    send_pkt(128'hDEADBEEFCAFEF00D5555AAAA3333CCCC, DOWN, R127, R128, MID);
    check("head_latency_valid", flit_t'(out_valid), 1);
    check("head_latency_is_head", flit_t'(out_is_head), 1);
    c0 = out_cnt;
    repeat (5) @(posedge clk_in);
    #1;
    out_ready = 1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk_in);
      #1;
      if (out_cnt >= c0 + 3) break;
    end
    out_ready = 0;
    repeat (5) @(posedge clk_in);
    #1;
    out_ready = 1;
    wait_drain();
    check("no_proto_err_clean", flit_t'(perr_cnt), 0);

    send(0, MID);
    send(1, 128'h11111111111111111111111111111111);
    send(0, UNI);
    send(0, RAMP);
    expect_packet(128'h22222222222222222222222222222222, HI, MIX, DOWN, R127);
    send_pkt(128'h22222222222222222222222222222222, HI, MIX, DOWN, R127);
    wait_drain();
    check("proto_err_count", flit_t'(perr_cnt), 2);

    send(1, 128'h33333333333333333333333333333333);
    send(0, UNI);
    send(0, RAMP);
    send(0, MIX);
    rst_n_in = 0;
    #2;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("midreset_held");
    rst_n_in = 1;
    expect_packet(128'h44444444444444444444444444444444, RAMP, HI, UNI, R128);
    send_pkt(128'h44444444444444444444444444444444, RAMP, HI, UNI, R128);
    wait_drain();
    check("proto_err_after_reset", flit_t'(perr_cnt), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flit_compressor.md
Name: flit_compressor

Overview:
- Transmit-side counterpart of the NoC flit decompressor.
- Accepts one uncompressed packet (head flit plus BODY_FLITS body flits) and buffers it.
- Computes one base/encoding pair per body flit and packs the pairs into the head flit's metadata field.
- Emits the head flit, then the delta-encoded body flits; the receiving decompressor restores each chunk as chunk = d - base (mod 2^CHUNK_SIZE).

Parameters:
- FLIT_WIDTH, 128, flit width in bits.
- CHUNK_SIZE, 8, chunk width; FLIT_WIDTH/CHUNK_SIZE = 16 chunks per flit.
- EN_BITS, 3, width of the encoding-bits field.
- BE_PAIR, 11, width of one pair (EN_BITS + CHUNK_SIZE).
- BODY_FLITS, 4, body flits per packet.
- META_START, 75, MSB of the metadata field in the head flit; field is BODY_FLITS*BE_PAIR = 44 bits, i.e. [75:32].

Ports:
- clk_in, input, 1, clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input flit valid.
- in_ready, output, 1, block accepts the input flit this cycle.
- in_is_head, input, 1, input flit is a head flit.
- data_in, input, FLIT_WIDTH, uncompressed flit.
- out_valid, output, 1, output flit valid.
- out_ready, input, 1, downstream accepts the output flit.
- out_is_head, output, 1, output flit is the head flit.
- data_out, output, FLIT_WIDTH, compressed flit.
- proto_err, output, 1, one-cycle pulse on an input framing violation.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_is_head=0, data_out=0, proto_err=0. FSM goes to IDLE; buffers and counters clear. Reset asserted mid-packet discards the partial packet with no output.
- Handshake: a transfer occurs when valid&&ready on a rising clk_in edge. While out_valid=1 and out_ready=0, data_out and out_is_head are held stable.
- States:
  - IDLE: in_ready=1. A head flit is stored in head_buf and the FSM goes to COLLECT with bcnt=0. A body flit in IDLE is dropped and proto_err pulses.
  - COLLECT: in_ready=1.
    - Body flit: stored in body_buf[bcnt]; its pair is computed combinationally and stored in meta[bcnt]; bcnt increments.
    - Head flit: proto_err pulses; the partial packet is discarded; the new head is stored; bcnt=0.
    - When bcnt reaches BODY_FLITS-1 and a body flit is accepted, the next state is EMIT_HEAD.
  - EMIT_HEAD: in_ready=0, out_valid=1, out_is_head=1. data_out = head_buf with [META_START:META_START-43] replaced by {meta[0],meta[1],meta[2],meta[3]} (pair 0 in the MSBs). All other head bits pass unchanged. On out_ready the FSM goes to EMIT_BODY with ocnt=0.
  - EMIT_BODY: in_ready=0, out_valid=1, out_is_head=0, data_out = encoded body_buf[ocnt]. Each out_ready increments ocnt; the last body goes to IDLE.
- Latency: head is valid on the cycle after the last body is accepted. Minimum packet period is 2*(BODY_FLITS+1) cycles; there is no overlap of collection and emission.
- Per-flit pair computation:
  - mn = min chunk, mx = max chunk, range = mx - mn.
  - w = bit width of range, with range=0 giving w=1.
  - If w <= 7: en_bits = w; base = (2^CHUNK_SIZE - mn) mod 2^CHUNK_SIZE; stored chunks d_i = x_i - mn.
  - If w = 8: raw mode; en_bits = 0, base = 0, chunks unchanged.
  - Decoder rule: base is applied iff en_bits != 0.
- Chunk ordering: chunk 0 = data[127:120].
- All arithmetic is unsigned mod 2^CHUNK_SIZE. Encoding is applied at emission from the stored mn/raw flag, or stored pre-encoded; either is acceptable if the outputs match.

Decomposition:
- Shared package (flit_pkg): FLIT_WIDTH, CHUNK_SIZE, EN_BITS, BE_PAIR, BODY_FLITS, META_START, the state enum {IDLE, COLLECT, EMIT_HEAD, EMIT_BODY}, and the EN_RAW=0 constant. The decompressor imports the same package.
- Sub-module be_pair_gen: purely combinational. Takes a flit and returns en_bits, base, mn, raw. Instantiated once, on the input path.

Test Plan:
- Body chunks all 0x10, others 0x00–0x0F ramp: expect pair0 = {3'd1, 8'hF0} for the uniform flit and {3'd4, 8'h00} for the ramp (mn=0 gives base 0). Ramp body is output unchanged; uniform body is output as all 0x00.
- Body chunks 0x00 and 0xFF mixed: en_bits=0, base=0, body passes raw; head bits outside [75:32] are unchanged.
- Body chunks 0x80..0x8F: en_bits=4, base=0x80, out chunks 0x00..0x0F. Loopback through the decompressor reproduces the original packet bit-exact.
- out_ready held low for 5 cycles during EMIT_HEAD and during body 2: data_out stays stable, in_ready=0, no flit is lost or duplicated.
- Body flit sent in IDLE, then head, 2 bodies, new head: proto_err pulses twice; only the second packet is emitted.
- rst_n_in asserted after 3 bodies, released, then a full packet sent: outputs are 0 during reset and only the new packet appears.
